health_alarm_scheduler: RTL

//  Sequences the HealthcareSystemPhase1 detector datapath and arbitrates its four

---
 rtl/health_alarm_scheduler.sv | 91 +++++++++
 1 files changed

// File: rtl/health_alarm_scheduler.sv
// health_alarm_scheduler: sample strobe, per-channel debounce and round-robin alarm presentation.
// Define ALARM_ESCALATE_EN to add the unacknowledged-alarm escalate timer.
module health_alarm_scheduler #(
  parameter int SAMPLE_PERIOD = 16,
  parameter int DEBOUNCE = 3
`ifdef ALARM_ESCALATE_EN
  , parameter int ESC_TIMEOUT = 64
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       presureAbnormality,
  input  logic       bloodAbnormality,
  input  logic       fallDetected,
  input  logic       temperatureAbnormality,
  input  logic [3:0] alarm_mask,
  input  logic       alarm_ready,
  output logic       sample_en,
  output logic       alarm_valid,
  output logic [1:0] alarm_id,
  output logic [3:0] pending_vec,
  output logic       escalate
);
  localparam int SW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {IDLE, ARB, PRESENT} state_t;
  state_t state, stateNext;
  logic [SW-1:0] smpCnt;
  logic [3:0][DW-1:0] dbCnt;
  logic [3:0] flags, armed, hold, qualify, pendingNext;
  logic [1:0] rr, sel;
  logic handshake;
  assign flags = {temperatureAbnormality, fallDetected, bloodAbnormality, presureAbnormality};
  assign sample_en = smpCnt == SW'(SAMPLE_PERIOD - 1);
  assign alarm_valid = state == PRESENT;
  assign handshake = alarm_valid && alarm_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) smpCnt <= '0;
    else smpCnt <= sample_en ? '0 : smpCnt + SW'(1);
  // hold protects the channel being selected or presented from a mask-driven clear
  always_comb begin
    sel = rr;
    for (int k = 3; k >= 0; k--)
      if (pending_vec[rr + 2'(k)]) sel = rr + 2'(k);
    for (int i = 0; i < 4; i++) begin
      hold[i] = (state == PRESENT && alarm_id == 2'(i)) || (state == ARB && sel == 2'(i));
      qualify[i] = sample_en && !alarm_mask[i] && flags[i] && armed[i] && dbCnt[i] == DW'(DEBOUNCE - 1);
      pendingNext[i] = qualify[i] || (pending_vec[i] && !(alarm_mask[i] && !hold[i])
                       && !(handshake && alarm_id == 2'(i)));
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dbCnt <= '0;
      armed <= '1;
      pending_vec <= '0;
    end else begin
      pending_vec <= pendingNext;
      for (int i = 0; i < 4; i++)
        if (alarm_mask[i]) dbCnt[i] <= '0;
        else if (sample_en) begin
          dbCnt[i] <= !flags[i] ? '0 : dbCnt[i] == DW'(DEBOUNCE) ? dbCnt[i] : dbCnt[i] + DW'(1);
          armed[i] <= flags[i] ? armed[i] && !qualify[i] : 1'b1;
        end
    end
  always_comb
    stateNext = state == IDLE ? (|pending_vec ? ARB : IDLE)
              : state == ARB  ? (|pending_vec ? PRESENT : IDLE)
              : (handshake ? IDLE : PRESENT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      alarm_id <= '0;
      rr <= '0;
    end else begin
      state <= stateNext;
      if (state == ARB) alarm_id <= sel;
      if (handshake) rr <= alarm_id + 2'd1;
    end
`ifdef ALARM_ESCALATE_EN
  localparam int EW = $clog2(ESC_TIMEOUT + 1);
  logic [EW-1:0] waitCnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) waitCnt <= '0;
    else if (handshake) waitCnt <= '0;
    else if (alarm_valid && waitCnt != EW'(ESC_TIMEOUT)) waitCnt <= waitCnt + EW'(1);
  assign escalate = waitCnt == EW'(ESC_TIMEOUT);
`else
  assign escalate = 1'b0;
`endif
endmodule
